// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing arbiter: datapath widths and ALUop encodings.
package alu_share_arbiter_pkg;

   localparam int XLEN    = 32;
   localparam int ALU_OPW = 4;

   typedef enum logic [ALU_OPW-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_XXX  = 4'hF
   } alu_op_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping at N-1.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic          en_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] gnt_idx_o,
   output logic          any_o
);

   always_comb begin
      logic [31:0] idx;
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_o     = 1'b0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         // modulo N keeps non-power-of-two sizes off the unused indices
         idx = (32'(ptr_i) + 32'(k)) % 32'(N);
         if (en_i && !any_o && req_i[idx[IW-1:0]]) begin
            gnt_o[idx[IW-1:0]] = 1'b1;
            gnt_idx_o          = idx[IW-1:0];
            any_o              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU among NREQ requesters,
// with a one-entry tagged response register.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*XLEN-1:0]    req_a,
   input  logic [NREQ*XLEN-1:0]    req_b,
   input  logic [NREQ*ALU_OPW-1:0] req_op,
   output logic [XLEN-1:0]         alu_a,
   output logic [XLEN-1:0]         alu_b,
   output logic [ALU_OPW-1:0]      alu_op,
   input  logic [XLEN-1:0]         alu_out,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [IDW-1:0]          rsp_id,
   output logic [XLEN-1:0]         rsp_data,
   output logic                    busy
);

   localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

   logic                 rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]       rsp_id_q, rsp_id_d;
   logic [XLEN-1:0]      rsp_data_q, rsp_data_d;
   logic [IDW-1:0]       ptr_q, ptr_d;

   logic                 can_issue;
   logic [NREQ-1:0]      gnt;
   logic [IDW-1:0]       gnt_idx;
   logic                 any_gnt;
   logic [IDW-1:0]       sel;

   logic [XLEN-1:0]      a_arr  [NREQ];
   logic [XLEN-1:0]      b_arr  [NREQ];
   logic [ALU_OPW-1:0]   op_arr [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
      assign a_arr[gi]  = req_a[gi*XLEN +: XLEN];
      assign b_arr[gi]  = req_b[gi*XLEN +: XLEN];
      assign op_arr[gi] = req_op[gi*ALU_OPW +: ALU_OPW];
   end

   // rsp_ready passes straight through so a draining slot can be refilled in the same cycle
   assign can_issue = ~rsp_valid_q | rsp_ready;

   rr_arbiter #(
      .N  (NREQ),
      .IW (IDW)
   ) u_rr (
      .req_i     (req_valid),
      .ptr_i     (ptr_q),
      .en_i      (can_issue & rst_n),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_o     (any_gnt)
   );

   assign req_ready = gnt;
   assign sel       = any_gnt ? gnt_idx : ptr_q;
   assign alu_a     = a_arr[sel];
   assign alu_b     = b_arr[sel];
   assign alu_op    = op_arr[sel];

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      ptr_d       = ptr_q;
      if (any_gnt) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = gnt_idx;
         rsp_data_d  = alu_out;
         ptr_d       = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDW'(1);
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         ptr_q       <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         ptr_q       <= ptr_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = rsp_valid_q | (|req_valid);

endmodule
